// File: rtl/mem_pkg.sv
// Shared encodings for the main-memory responder and the cache controller that drives it.
package mem_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_BYTES     = WORDS_PER_BLOCK * 4;
  localparam int BLOCK_OFF_W     = $clog2(BLOCK_BYTES);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WCOLLECT = 3'd1;
  localparam logic [2:0] ST_LAT      = 3'd2;
  localparam logic [2:0] ST_RBURST   = 3'd3;
  localparam logic [2:0] ST_WDONE    = 3'd4;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Byte-offset width of a block holding the given number of 32-bit words.
  function automatic int block_off_w(input int words);
    return $clog2(words * 4);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module mem_lat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/main_mem_ctrl.sv
// Block-oriented main-memory responder: one request, then a latency wait and a 4-word beat stream.
// Optional MEM_CRITICAL_WORD_FIRST_EN starts read bursts at the requested word.
module main_mem_ctrl #(
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
  parameter int LATENCY         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic              wr_done,
  output logic              busy
);
  import mem_pkg::*;

  localparam int OFF_W  = block_off_w(WORDS_PER_BLOCK);
  localparam int WIDX_W = OFF_W - 2;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WIDX_W-1:0] LAST_BEAT = WIDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  logic [7:0] memory [0:(1<<ADDR_W)-1];

  logic [2:0]              state_reg, state_next;
  logic [ADDR_W-OFF_W-1:0] base_reg, base_next;
  logic                    dir_reg, dir_next;
  logic [WIDX_W-1:0]       start_reg, start_next;
  logic [WIDX_W-1:0]       beat_reg, beat_next;
  logic                    rd_valid_reg, rd_valid_next;
  logic                    rd_last_reg, rd_last_next;
  logic [31:0]             rd_data_reg, rd_data_next;

  logic                    lat_load, lat_en, lat_done, mem_we;
  logic [WIDX_W-1:0]       rd_idx, rd_widx;
  logic [ADDR_W-1:0]       rd_word_addr, wr_word_addr;
  logic [31:0]             rd_word;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  mem_lat_counter #(.WIDTH(LAT_W)) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lat_load),
    .load_value (LAT_LOAD),
    .en         (lat_en),
    .done       (lat_done)
  );

  // The first beat is fetched on the LAT exit edge, before beat_reg has advanced.
  assign rd_idx       = (state_reg == ST_RBURST) ? beat_reg : '0;
  assign rd_widx      = start_reg + rd_idx;
  assign rd_word_addr = {base_reg, rd_widx, 2'b00};
  assign wr_word_addr = {base_reg, beat_reg, 2'b00};

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_word[8*gi +: 8] = memory[{rd_word_addr[ADDR_W-1:2], 2'(gi)}];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        memory[{wr_word_addr[ADDR_W-1:2], 2'(b)}] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    dir_next      = dir_reg;
    start_next    = start_reg;
    beat_next     = beat_reg;
    rd_valid_next = 1'b0;
    rd_last_next  = 1'b0;
    rd_data_next  = rd_data_reg;
    lat_load      = 1'b0;
    lat_en        = 1'b0;
    mem_we        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          base_next = req_addr[ADDR_W-1:OFF_W];
          dir_next  = req_write;
          beat_next = '0;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
          start_next = req_addr[OFF_W-1:2];
`else
          start_next = '0;
`endif
          if (req_write == REQ_WRITE) begin
            state_next = ST_WCOLLECT;
          end else begin
            state_next = ST_LAT;
            lat_load   = 1'b1;
          end
        end
      end
      ST_WCOLLECT: begin
        if (wr_valid) begin
          mem_we    = 1'b1;
          beat_next = beat_reg + WIDX_W'(1);
          if (beat_reg == LAST_BEAT) begin
            state_next = ST_LAT;
            lat_load   = 1'b1;
          end
        end
      end
      ST_LAT: begin
        lat_en = 1'b1;
        if (lat_done) begin
          if (dir_reg == REQ_WRITE) begin
            state_next = ST_WDONE;
          end else begin
            state_next    = ST_RBURST;
            rd_valid_next = 1'b1;
            rd_data_next  = rd_word;
            beat_next     = WIDX_W'(1);
          end
        end
      end
      ST_RBURST: begin
        if (rd_last_reg) begin
          state_next = ST_IDLE;
        end else begin
          rd_valid_next = 1'b1;
          rd_data_next  = rd_word;
          rd_last_next  = (beat_reg == LAST_BEAT);
          beat_next     = beat_reg + WIDX_W'(1);
        end
      end
      ST_WDONE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      base_reg     <= '0;
      dir_reg      <= REQ_READ;
      start_reg    <= '0;
      beat_reg     <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      dir_reg      <= dir_next;
      start_reg    <= start_next;
      beat_reg     <= beat_next;
      rd_valid_reg <= rd_valid_next;
      rd_last_reg  <= rd_last_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign wr_done   = (state_reg == ST_WDONE);
  assign rd_valid  = rd_valid_reg;
  assign rd_last   = rd_last_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed-plus-random bench for main_mem_ctrl against a byte-array memory model.
// Honours MEM_CRITICAL_WORD_FIRST_EN when computing expected read beat order.
module tb_main_mem_ctrl;
  import mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LAT    = 4;
  localparam int W      = WORDS_PER_BLOCK;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              req_ready, rd_valid, rd_last, wr_done, busy;
  logic [31:0]       rd_data;

  main_mem_ctrl #(.ADDR_W(ADDR_W), .WORDS_PER_BLOCK(W), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] model_mem [0:(1<<ADDR_W)-1];
  int n_checks = 0, n_pass = 0, n_fail = 0;
  int hs_count = 0, hs_exp = 0;

  always @(posedge clk) if (rst_n && req_valid && req_ready) hs_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int start_idx(input int a);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    return (a / 4) % W;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
  endfunction

  // Byte address of read beat j for a request at byte address a.
  function automatic int beat_addr(input int a, input int j);
    int base;
    base = a - (a % BLOCK_BYTES);
    return base + 4 * ((start_idx(a) + j) % W);
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic wr, input int a);
    int waited;
    waited = 0;
    req_write = wr;
    req_addr  = ADDR_W'(a);
    req_valid = 1'b1;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_bound", 32'(waited < 200), 1);
    @(posedge clk);
    hs_exp++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // A beat seen at negedge t is sampled by the cache on edge t+1.
  task automatic do_read(input int a);
    int j;
    logic exp_v;
    issue(1'b0, a);
    wr_valid = 1'b1;
    for (int t = 1; t <= LAT + W; t++) begin
      wr_data = $urandom;
      @(negedge clk);
      exp_v = (t >= LAT) && (t < LAT + W);
      j = t - LAT;
      check("rd_valid", 32'(rd_valid), 32'(exp_v));
      check("rd_last", 32'(rd_last), 32'(exp_v && (j == W - 1)));
      if (exp_v) check("rd_data", rd_data, model_word(beat_addr(a, j)));
      check("req_ready_rd", 32'(req_ready), 32'(t == LAT + W));
    end
    wr_valid = 1'b0;
    $display("read  addr=0x%03h start=%0d", a, start_idx(a));
  endtask

  task automatic do_write(input int a, input logic [31:0] wd [W], input int gap);
    int t, stalls, base;
    base = a - (a % BLOCK_BYTES);
    issue(1'b1, a);
    t = 0;
    stalls = 0;
    for (int k = 0; k < W; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0;
          wr_data  = $urandom;
          @(negedge clk);
          t++;
          stalls++;
        end
      end
      wr_valid = 1'b1;
      wr_data  = wd[k];
      @(negedge clk);
      t++;
      for (int b = 0; b < 4; b++) model_mem[base + 4*k + b] = wd[k][8*b +: 8];
    end
    wr_data = $urandom;
    while (!wr_done && t < W + stalls + LAT + 20) begin
      @(negedge clk);
      t++;
    end
    check("wr_done_latency", t, W + stalls + LAT);
    @(negedge clk);
    wr_valid = 1'b0;
    check("wr_done_pulse", 32'(wr_done), 0);
    check("req_ready_wr", 32'(req_ready), 1);
    $display("write addr=0x%03h gap=%0d stalls=%0d", a, gap, stalls);
  endtask

  initial begin
    logic [31:0] wds [W];
    int a, seen, bad;

    for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_last", 32'(rd_last), 0);
    check("rst_wr_done", 32'(wr_done), 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(0);

    wds[0] = 32'h0000_00FF; wds[1] = 32'h11; wds[2] = 32'h22; wds[3] = 32'h33;
    do_write(0, wds, 0);
    check("mem_byte0", 32'(dut.memory[0]), 32'h0000_00FF);
    check("mem_byte1", 32'(dut.memory[1]), 32'h0);
    check("mem_byte4", 32'(dut.memory[4]), 32'h11);
    do_read(0);

    for (int k = 0; k < W; k++) wds[k] = $urandom;
    do_write(12'h040, wds, 2);
    do_read(12'h040);

    for (int k = 0; k < W; k++) wds[k] = $urandom;
    do_write(12'h200, wds, 0);
    do_read(12'h208);

    for (int it = 0; it < 5; it++) begin
      a = int'($urandom_range(0, (1 << ADDR_W) - 1));
      for (int k = 0; k < W; k++) wds[k] = $urandom;
      do_write(a, wds, int'($urandom_range(0, 3)));
      do_read(int'($urandom_range(0, BLOCK_BYTES - 1)) + (a - (a % BLOCK_BYTES)));
    end

    // Reset after beat 1 of a read burst.
    issue(1'b0, 12'h004);
    for (int t = 1; t <= LAT + 1; t++) @(negedge clk);
    check("rd_beat1_pre_rst", rd_data, model_word(beat_addr(12'h004, 1)));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_req_ready", 32'(req_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_data", rd_data, 0);
    bad = 0;
    for (int i = 0; i < BLOCK_BYTES; i++) if (dut.memory[i] !== model_mem[i]) bad++;
    check("mid_rst_mem_kept", bad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(12'h004);

    // Reset after two write beats: those bytes stay, no wr_done follows.
    issue(1'b1, 12'h100);
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      for (int b = 0; b < 4; b++) model_mem[12'h100 + 4*k + b] = wr_data[8*b +: 8];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("wr_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < LAT + 4; t++) begin
      @(negedge clk);
      if (wr_done) seen++;
    end
    check("wr_rst_no_done", seen, 0);
    do_read(12'h100);

    // req_valid held through a busy read: one handshake per request.
    req_write = 1'b0;
    req_addr  = ADDR_W'(12'h208);
    req_valid = 1'b1;
    check("hold_ready_idle", 32'(req_ready), 1);
    @(posedge clk);
    hs_exp++;
    for (int t = 0; t <= LAT + W; t++) begin
      @(negedge clk);
      check("hold_req_ready", 32'(req_ready), 32'(t == LAT + W));
    end
    @(posedge clk);
    hs_exp++;
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 1; t <= LAT + W; t++) @(negedge clk);
    check("hold_idle_after", 32'(req_ready), 1);
    check("handshake_count", hs_count, hs_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Sequential main-memory responder at the memory-facing end of the cache subsystem. It accepts block-refill (read) and block-writeback (write) requests from the cache controller over a valid/ready request channel. After a programmable access latency it returns or absorbs one 4-word block as a beat stream. Storage is a byte-addressed array named `memory`, little-endian, so byte-level inspection from benches stays unchanged.

## Interface
Parameters:
- ADDR_W, 10: byte address width; array holds 2^ADDR_W bytes.
- WORDS_PER_BLOCK, 4: 32-bit words per block (power of two, ≥2).
- LATENCY, 4: access-latency cycles, ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  0 = block read (refill), 1 = block write (writeback).
- req_addr  in  ADDR_W  byte address; block offset bits are ignored except under the configuration macro.
- wr_valid  in  1  write-data beat present.
- wr_data  in  32  write-data beat.
- rd_valid  out  1  read-data beat valid.
- rd_data  out  32  read-data beat.
- rd_last  out  1  final read beat.
- wr_done  out  1  one-cycle pulse when a block write is committed.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WCOLLECT, LAT, RBURST, WDONE.
- IDLE: req_ready=1. When req_valid is high, the request is accepted on that edge. The block base ({req_addr[ADDR_W-1:4],4'b0} for 4 words), the direction and the start word index are latched.
  - Write request: go to WCOLLECT.
  - Read request: go to LAT.
- WCOLLECT: each cycle with wr_valid=1 writes wr_data to the 4 bytes at base+4·k, where k counts 0..WORDS_PER_BLOCK-1 in order. Cycles with wr_valid=0 are stalls with no effect. After the last beat, go to LAT.
- LAT: counts exactly LATENCY cycles, then goes to RBURST (read) or WDONE (write).
- RBURST: drives WORDS_PER_BLOCK consecutive beats with rd_valid=1 and no backpressure; the cache must sink every beat.
  - Beat j carries the word at base+4·((start+j) mod WORDS_PER_BLOCK). Without the macro, start=0.
  - rd_last is high on beat WORDS_PER_BLOCK-1. Go to IDLE after that beat.
- WDONE: wr_done=1 for one cycle, then IDLE.
- Requests arriving while busy are not accepted; req_valid must be held until req_ready.
- wr_valid outside WCOLLECT is ignored.
- Address arithmetic wraps within the block only; a block never crosses the array end because bases are aligned.
- Reset values: req_ready=1, busy=0, rd_valid=0, rd_last=0, wr_done=0, rd_data=0, all counters 0.
- Reset does not clear `memory`; the array is zero-initialised at time 0.
- Reset mid-operation returns the FSM to IDLE immediately. Bytes already written in WCOLLECT are kept. A partial read burst is abandoned and no wr_done is issued.

## Timing
- Read: request accepted at edge 0. LAT occupies edges 1..LATENCY. Beats occupy edges LATENCY+1 .. LATENCY+WORDS_PER_BLOCK. Earliest next acceptance is the following edge.
- Write: each beat is written at the edge where it is sampled. wr_done is high in the cycle LATENCY+1 edges after the last beat is sampled.
- Read-after-write to the same block returns the new data, since the array is updated in WCOLLECT.
- rd_data and rd_valid are registered outputs.

## Configuration
- MEM_CRITICAL_WORD_FIRST_EN defined: start = req_addr[3:2] (generally the word-index bits). The read burst begins at the requested word and wraps within the block.
- Undefined: start = 0 and beats are always in ascending order.
- Write beat order is ascending in both cases.

## Structure
- Shared package `mem_pkg`: state enum, WORDS_PER_BLOCK, BLOCK_BYTES, derived offset-width constant, request/direction encodings. The cache controller imports the same package.
- One sub-module, `mem_lat_counter`: a loadable down-counter with a done flag, used by the LAT state.

## Test plan
- Reset, then read block 0x000 with LATENCY=4 -> rd_valid on edges 5..8, data 0x00000000 ×4, rd_last on edge 8.
- Write block 0x000 with beats 0x000000FF, 0x11, 0x22, 0x33 -> memory[0]=0xFF, memory[4]=0x11; wr_done pulses 5 edges after the last beat. Read back -> same four words.
- Write with wr_valid gaps of 2 cycles between beats -> same memory image; wr_done delayed by exactly the total stall cycles.
- Under MEM_CRITICAL_WORD_FIRST_EN, read at 0x208 after filling the block with words W0..W3 -> beat order W2, W3, W0, W1, with rd_last on W1.
- Assert rst_n low mid-RBURST (after beat 1) -> rd_valid=0 immediately, req_ready=1, memory unchanged. Issue a new request -> served normally.
- req_valid held high during a busy read -> not accepted until IDLE. A req_ready/req_valid handshake occurs exactly once per request.
